jtag_dma_engine: RTL and testbench

- System-clock-domain bus master that consumes the launch requests produced by the JTAG chain-1 controller.
- On a write launch it drains the DMA-side half of the ping-pong buffer onto the system bus as one burst.
- On a read launch it fills that half from the system bus.
- It reports completion back to the JTAG side through switch_ready, which tells the chain controller when a buffer swap is safe.

---
 rtl/jtag_dma_engine.sv | 175 +++++++++++++++++
 tb/tb_jtag_dma_engine.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dma_engine.sv
// System-clock bus master that drains or fills the DMA half of the JTAG ping-pong
// buffer on launch requests synchronised from the JTCK domain.
module jtag_dma_engine #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        JRSTN,
   input  logic [31:0] dma_address,
   input  logic [3:0]  dma_byte_enable,
   input  logic [7:0]  dma_burst_size,
   input  logic        dma_data_ready,
   input  logic        dma_readReady,
   output logic        switch_ready,
   output logic [8:0]  pp_address,
   output logic        pp_writeEnable,
   output logic [31:0] pp_dataIn,
   input  logic [31:0] pp_dataOut,
   output logic        bus_request,
   input  logic        bus_grant,
   output logic        bus_begin_transaction_out,
   output logic [31:0] bus_address_data_out,
   output logic [3:0]  bus_byte_enables_out,
   output logic [7:0]  bus_burst_size_out,
   output logic        bus_read_n_write_out,
   output logic        bus_data_valid_out,
   output logic        bus_end_transaction_out,
   input  logic [31:0] bus_address_data_in,
   input  logic        bus_data_valid_in,
   input  logic        bus_busy_in,
   input  logic        bus_end_transaction_in,
   input  logic        bus_error_in,
   output logic        dma_busy,
   output logic        dma_error
);

   typedef enum logic [3:0] {
      IDLE, W_REQ, W_BEGIN, W_FETCH, W_DATA, W_END, R_REQ, R_BEGIN, R_DATA
   } state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] wr_sync, rd_sync;
   logic wr_prev, rd_prev;
   logic sync_wr, sync_rd, wr_edge, rd_edge;

   logic [7:0]  counter, counter_next;
   logic        filled, filled_next;
   logic        error_next, capture;
   logic [31:0] cap_address;
   logic [3:0]  cap_be;
   logic [7:0]  cap_size;
   logic        rd_accept;

   assign sync_wr = wr_sync[SYNC_STAGES-1];
   assign sync_rd = rd_sync[SYNC_STAGES-1];
   assign wr_edge = sync_wr & ~wr_prev;
   assign rd_edge = sync_rd & ~rd_prev;

   // A read beat is stored only until the requested word count has arrived
   assign rd_accept = (state == R_DATA) & bus_data_valid_in & ~filled;

   always_ff @(posedge clock or negedge JRSTN) begin
      if (!JRSTN) begin
         wr_sync      <= '0;
         rd_sync      <= '0;
         wr_prev      <= 1'b0;
         rd_prev      <= 1'b0;
         state        <= IDLE;
         counter      <= 8'd0;
         filled       <= 1'b0;
         dma_error    <= 1'b0;
         cap_address  <= 32'd0;
         cap_be       <= 4'd0;
         cap_size     <= 8'd0;
         switch_ready <= 1'b1;
      end else begin
         wr_sync      <= {wr_sync[SYNC_STAGES-2:0], dma_data_ready};
         rd_sync      <= {rd_sync[SYNC_STAGES-2:0], dma_readReady};
         wr_prev      <= sync_wr;
         rd_prev      <= sync_rd;
         state        <= state_next;
         counter      <= counter_next;
         filled       <= filled_next;
         dma_error    <= error_next;
         switch_ready <= (state == IDLE) & ~sync_wr & ~sync_rd;
         if (capture) begin
            cap_address <= dma_address;
            cap_be      <= dma_byte_enable;
            cap_size    <= dma_burst_size;
         end
      end
   end

   always_comb begin
      state_next   = state;
      counter_next = counter;
      filled_next  = filled;
      error_next   = dma_error;
      capture      = 1'b0;
      if (state != IDLE && bus_error_in) begin
         state_next = IDLE;
         error_next = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (wr_edge || rd_edge) begin
                  state_next   = wr_edge ? W_REQ : R_REQ;
                  capture      = 1'b1;
                  error_next   = 1'b0;
                  counter_next = 8'd0;
                  filled_next  = 1'b0;
               end
            end
            W_REQ:   if (bus_grant) state_next = W_BEGIN;
            W_BEGIN: state_next = W_FETCH;
            W_FETCH: state_next = W_DATA;
            W_DATA: begin
               if (!bus_busy_in) begin
                  if (counter == cap_size) begin
                     state_next = W_END;
                  end else begin
                     counter_next = counter + 8'd1;
                     state_next   = W_FETCH;
                  end
               end
            end
            W_END:   state_next = IDLE;
            R_REQ:   if (bus_grant) state_next = R_BEGIN;
            R_BEGIN: state_next = R_DATA;
            R_DATA: begin
               if (rd_accept) begin
                  if (counter == cap_size) filled_next = 1'b1;
                  else                     counter_next = counter + 8'd1;
               end
               // An end that arrives with the final beat still counts as complete
               if (bus_end_transaction_in) begin
                  state_next = IDLE;
                  if (!(filled || (rd_accept && counter == cap_size))) error_next = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      bus_request               = (state != IDLE);
      dma_busy                  = (state != IDLE);
      bus_begin_transaction_out = (state == W_BEGIN) || (state == R_BEGIN);
      bus_read_n_write_out      = (state == R_BEGIN);
      bus_data_valid_out        = (state == W_DATA);
      bus_address_data_out      = 32'd0;
      bus_byte_enables_out      = 4'd0;
      bus_burst_size_out        = 8'd0;
      pp_address                = 9'd0;
      pp_writeEnable            = rd_accept;
      pp_dataIn                 = rd_accept ? bus_address_data_in : 32'd0;
      // Abort strobe only once the slave has seen a begin
      bus_end_transaction_out   = (state == W_END) ||
                                  (bus_error_in && (state == W_FETCH || state == W_DATA ||
                                                    state == R_DATA));
      if (bus_begin_transaction_out) begin
         bus_address_data_out = cap_address;
         bus_byte_enables_out = cap_be;
         bus_burst_size_out   = cap_size;
      end
      // The buffer address is held through the data beat so a stalled beat stays stable
      if (state == W_FETCH || state == W_DATA || state == R_DATA) pp_address = {1'b0, counter};
      if (state == W_DATA) begin
         bus_address_data_out = pp_dataOut;
         bus_byte_enables_out = cap_be;
      end
   end

endmodule

// File: tb/tb_jtag_dma_engine.sv
// Directed bench for jtag_dma_engine: write/read bursts, stalls, aborts, errors and reset.
module tb_jtag_dma_engine;

   logic        clock;
   logic        JRSTN;
   logic [31:0] dma_address;
   logic [3:0]  dma_byte_enable;
   logic [7:0]  dma_burst_size;
   logic        dma_data_ready;
   logic        dma_readReady;
   logic        switch_ready;
   logic [8:0]  pp_address;
   logic        pp_writeEnable;
   logic [31:0] pp_dataIn;
   logic [31:0] pp_dataOut;
   logic        bus_request;
   logic        bus_grant;
   logic        bus_begin_transaction_out;
   logic [31:0] bus_address_data_out;
   logic [3:0]  bus_byte_enables_out;
   logic [7:0]  bus_burst_size_out;
   logic        bus_read_n_write_out;
   logic        bus_data_valid_out;
   logic        bus_end_transaction_out;
   logic [31:0] bus_address_data_in;
   logic        bus_data_valid_in;
   logic        bus_busy_in;
   logic        bus_end_transaction_in;
   logic        bus_error_in;
   logic        dma_busy;
   logic        dma_error;

   int checks = 0;
   int failures = 0;

   jtag_dma_engine #(.SYNC_STAGES(2)) dut (
      .clock(clock), .JRSTN(JRSTN),
      .dma_address(dma_address), .dma_byte_enable(dma_byte_enable),
      .dma_burst_size(dma_burst_size), .dma_data_ready(dma_data_ready),
      .dma_readReady(dma_readReady), .switch_ready(switch_ready),
      .pp_address(pp_address), .pp_writeEnable(pp_writeEnable),
      .pp_dataIn(pp_dataIn), .pp_dataOut(pp_dataOut),
      .bus_request(bus_request), .bus_grant(bus_grant),
      .bus_begin_transaction_out(bus_begin_transaction_out),
      .bus_address_data_out(bus_address_data_out),
      .bus_byte_enables_out(bus_byte_enables_out),
      .bus_burst_size_out(bus_burst_size_out),
      .bus_read_n_write_out(bus_read_n_write_out),
      .bus_data_valid_out(bus_data_valid_out),
      .bus_end_transaction_out(bus_end_transaction_out),
      .bus_address_data_in(bus_address_data_in),
      .bus_data_valid_in(bus_data_valid_in), .bus_busy_in(bus_busy_in),
      .bus_end_transaction_in(bus_end_transaction_in), .bus_error_in(bus_error_in),
      .dma_busy(dma_busy), .dma_error(dma_error)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Ping-pong buffer model with one-cycle read latency; the bench preloads via tb_we
   logic [31:0] mem [0:511];
   logic        tb_we;
   logic [8:0]  tb_waddr;
   logic [31:0] tb_wdata;

   always @(posedge clock) begin
      if (tb_we)               mem[tb_waddr]   <= tb_wdata;
      else if (pp_writeEnable) mem[pp_address] <= pp_dataIn;
      pp_dataOut <= mem[pp_address];
   end

   // Bus monitor sampling on the falling edge
   logic        mon_clear;
   int          mon_begins, mon_ends, mon_beats, mon_we, mon_stalls, hold_viol;
   logic [31:0] mon_addr;
   logic [7:0]  mon_burst;
   logic [3:0]  mon_be;
   logic        mon_rnw, saw_sr_low, prev_stall;
   logic [31:0] prev_val;
   logic [31:0] beat_log [0:15];

   always @(negedge clock) begin
      if (mon_clear) begin
         mon_begins <= 0; mon_ends <= 0; mon_beats <= 0; mon_we <= 0;
         mon_stalls <= 0; hold_viol <= 0; saw_sr_low <= 1'b0; prev_stall <= 1'b0;
         mon_rnw <= 1'b0; mon_addr <= 32'd0; mon_burst <= 8'd0; mon_be <= 4'd0;
      end else begin
         if (bus_begin_transaction_out) begin
            mon_begins <= mon_begins + 1;
            mon_addr   <= bus_address_data_out;
            mon_burst  <= bus_burst_size_out;
            mon_be     <= bus_byte_enables_out;
            mon_rnw    <= bus_read_n_write_out;
         end
         if (bus_data_valid_out && !bus_busy_in) begin
            if (mon_beats < 16) beat_log[mon_beats] <= bus_address_data_out;
            mon_beats <= mon_beats + 1;
         end
         if (bus_data_valid_out && bus_busy_in) mon_stalls <= mon_stalls + 1;
         if (prev_stall && (!bus_data_valid_out || bus_address_data_out !== prev_val))
            hold_viol <= hold_viol + 1;
         prev_stall <= bus_data_valid_out && bus_busy_in;
         prev_val   <= bus_address_data_out;
         if (bus_end_transaction_out) mon_ends <= mon_ends + 1;
         if (pp_writeEnable) mon_we <= mon_we + 1;
         if (!switch_ready) saw_sr_low <= 1'b1;
      end
   end

   logic post_err_req;

   task automatic preload(input int addr, input logic [31:0] data);
      tb_waddr = addr[8:0];
      tb_wdata = data;
      tb_we    = 1'b1;
      @(posedge clock); #1;
      tb_we    = 1'b0;
   endtask

   task automatic clear_monitor();
      mon_clear = 1'b1;
      @(posedge clock); #1;
      mon_clear = 1'b0;
   endtask

   // Acts as a granting write slave; optional stall of 3 cycles or an error on a given beat
   task automatic run_write(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] size,
                            input int stall_beat, input int err_beat, input logic also_read,
                            output logic timed_out);
      int acc = 0;
      int stalls = 0;
      logic seen_busy = 1'b0;
      logic err_pending = 1'b0;
      clear_monitor();
      post_err_req    = 1'bx;
      dma_address     = addr;
      dma_byte_enable = be;
      dma_burst_size  = size;
      dma_data_ready  = 1'b1;
      dma_readReady   = also_read;
      bus_grant       = 1'b1;
      timed_out       = 1'b1;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(posedge clock); #1;
         if (cyc == 10) begin
            dma_data_ready = 1'b0;
            dma_readReady  = 1'b0;
         end
         if (err_pending) begin
            post_err_req = bus_request;
            err_pending  = 1'b0;
         end
         bus_busy_in  = 1'b0;
         bus_error_in = 1'b0;
         if (dma_busy) seen_busy = 1'b1;
         if (bus_data_valid_out) begin
            if (acc == stall_beat && stalls < 3) begin
               bus_busy_in = 1'b1;
               stalls++;
            end else if (acc == err_beat) begin
               bus_error_in = 1'b1;
               err_pending  = 1'b1;
            end
            if (!bus_busy_in) acc++;
         end
         if (seen_busy && !dma_busy && !err_pending && cyc >= 12) begin
            timed_out = 1'b0;
            break;
         end
      end
      bus_busy_in  = 1'b0;
      bus_error_in = 1'b0;
   endtask

   // Acts as a read slave returning base+1, base+2, ... then ending the transaction
   task automatic run_read(input logic [31:0] addr, input logic [7:0] size, input int nbeats,
                           input logic [31:0] base, output logic timed_out);
      logic started = 1'b0;
      logic ended = 1'b0;
      int sent = 0;
      clear_monitor();
      dma_address     = addr;
      dma_byte_enable = 4'hF;
      dma_burst_size  = size;
      dma_readReady   = 1'b1;
      bus_grant       = 1'b1;
      timed_out       = 1'b1;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(posedge clock); #1;
         if (cyc == 10) dma_readReady = 1'b0;
         bus_data_valid_in      = 1'b0;
         bus_address_data_in    = 32'd0;
         bus_end_transaction_in = 1'b0;
         if (started && !ended) begin
            if (sent < nbeats) begin
               bus_data_valid_in   = 1'b1;
               bus_address_data_in = base + 32'(sent + 1);
               sent++;
            end else begin
               bus_end_transaction_in = 1'b1;
               ended = 1'b1;
            end
         end
         if (bus_begin_transaction_out) started = 1'b1;
         if (ended && !bus_end_transaction_in && !dma_busy && cyc >= 12) begin
            timed_out = 1'b0;
            break;
         end
      end
      bus_data_valid_in      = 1'b0;
      bus_end_transaction_in = 1'b0;
   endtask

   task automatic test_reset();
      JRSTN = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (switch_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_switch_ready: got %b expected 1", switch_ready);
      end
      checks++;
      if ({bus_request, bus_begin_transaction_out, bus_data_valid_out, bus_end_transaction_out,
           bus_read_n_write_out, pp_writeEnable, dma_busy, dma_error} !== 8'd0) begin
         failures++;
         $display("[TB] FAIL reset_flags: got %b expected 00000000",
                  {bus_request, bus_begin_transaction_out, bus_data_valid_out,
                   bus_end_transaction_out, bus_read_n_write_out, pp_writeEnable,
                   dma_busy, dma_error});
      end
      checks++;
      if ({bus_address_data_out, bus_byte_enables_out, bus_burst_size_out, pp_address} !== 53'd0)
      begin
         failures++;
         $display("[TB] FAIL reset_buses: addr_data %h pp_address %h expected 0",
                  bus_address_data_out, pp_address);
      end
      JRSTN = 1'b1;
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic test_write_burst();
      logic to;
      logic [31:0] exp;
      for (int i = 0; i < 4; i++) preload(i, 32'hA0 + 32'(i));
      run_write(32'h1000, 4'hF, 8'd3, -1, -1, 1'b0, to);
      repeat (4) @(posedge clock);
      #1;
      checks++;
      if (to !== 1'b0) begin
         failures++;
         $display("[TB] FAIL write_timeout: got %b expected 0", to);
      end
      checks++;
      if (mon_begins !== 1 || mon_addr !== 32'h1000 || mon_burst !== 8'd3 ||
          mon_rnw !== 1'b0 || mon_be !== 4'hF) begin
         failures++;
         $display("[TB] FAIL write_begin: got n=%0d addr=%h burst=%0d rnw=%b be=%h expected n=1 addr=00001000 burst=3 rnw=0 be=f",
                  mon_begins, mon_addr, mon_burst, mon_rnw, mon_be);
      end
      checks++;
      if (mon_beats !== 4 || mon_ends !== 1) begin
         failures++;
         $display("[TB] FAIL write_counts: got beats=%0d ends=%0d expected 4 and 1",
                  mon_beats, mon_ends);
      end
      for (int i = 0; i < 4; i++) begin
         exp = 32'hA0 + 32'(i);
         checks++;
         if (beat_log[i] !== exp) begin
            failures++;
            $display("[TB] FAIL write_beat%0d: got %h expected %h", i, beat_log[i], exp);
         end
      end
      checks++;
      if (saw_sr_low !== 1'b1 || switch_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL write_switch_ready: saw_low=%b now=%b expected 1 and 1",
                  saw_sr_low, switch_ready);
      end
   endtask

   task automatic test_write_busy();
      logic to;
      logic [31:0] exp;
      for (int i = 0; i < 4; i++) preload(i, 32'hB0 + 32'(i));
      run_write(32'h2000, 4'hF, 8'd3, 2, -1, 1'b0, to);
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (to !== 1'b0 || mon_beats !== 4 || mon_stalls !== 3 || hold_viol !== 0) begin
         failures++;
         $display("[TB] FAIL busy_counts: timeout=%b beats=%0d stalls=%0d hold_viol=%0d expected 0 4 3 0",
                  to, mon_beats, mon_stalls, hold_viol);
      end
      for (int i = 0; i < 4; i++) begin
         exp = 32'hB0 + 32'(i);
         checks++;
         if (beat_log[i] !== exp) begin
            failures++;
            $display("[TB] FAIL busy_beat%0d: got %h expected %h", i, beat_log[i], exp);
         end
      end
   endtask

   task automatic test_read_burst();
      logic to;
      preload(2, 32'h12345678);
      run_read(32'h8000, 8'd1, 2, 32'hDEAD0000, to);
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (to !== 1'b0 || mon_begins !== 1 || mon_rnw !== 1'b1 || mon_burst !== 8'd1) begin
         failures++;
         $display("[TB] FAIL read_begin: timeout=%b n=%0d rnw=%b burst=%0d expected 0 1 1 1",
                  to, mon_begins, mon_rnw, mon_burst);
      end
      checks++;
      if (mem[0] !== 32'hDEAD0001 || mem[1] !== 32'hDEAD0002 || mem[2] !== 32'h12345678) begin
         failures++;
         $display("[TB] FAIL read_data: got %h %h %h expected dead0001 dead0002 12345678",
                  mem[0], mem[1], mem[2]);
      end
      checks++;
      if (mon_we !== 2 || dma_error !== 1'b0) begin
         failures++;
         $display("[TB] FAIL read_we_error: got we=%0d err=%b expected 2 and 0", mon_we, dma_error);
      end
   endtask

   task automatic test_read_early_end();
      logic to;
      logic [31:0] exp;
      for (int i = 0; i < 4; i++) preload(i, 32'h55550000 + 32'(i));
      run_read(32'h9000, 8'd3, 1, 32'hCAFE0000, to);
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (to !== 1'b0 || dma_error !== 1'b1 || dma_busy !== 1'b0 || mem[0] !== 32'hCAFE0001) begin
         failures++;
         $display("[TB] FAIL early_end: timeout=%b err=%b busy=%b mem0=%h expected 0 1 0 cafe0001",
                  to, dma_error, dma_busy, mem[0]);
      end
      for (int i = 1; i < 4; i++) begin
         exp = 32'h55550000 + 32'(i);
         checks++;
         if (mem[i] !== exp) begin
            failures++;
            $display("[TB] FAIL early_end_mem%0d: got %h expected %h", i, mem[i], exp);
         end
      end
      run_write(32'h4000, 4'h3, 8'd0, -1, -1, 1'b0, to);
      #1;
      checks++;
      if (to !== 1'b0 || dma_error !== 1'b0 || mon_beats !== 1 || beat_log[0] !== 32'hCAFE0001) begin
         failures++;
         $display("[TB] FAIL error_clear: timeout=%b err=%b beats=%0d beat0=%h expected 0 0 1 cafe0001",
                  to, dma_error, mon_beats, beat_log[0]);
      end
   endtask

   task automatic test_bus_error();
      logic to;
      for (int i = 0; i < 4; i++) preload(i, 32'hC0 + 32'(i));
      run_write(32'h6000, 4'hF, 8'd3, -1, 1, 1'b0, to);
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (to !== 1'b0 || mon_ends !== 1 || dma_error !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bus_error: timeout=%b ends=%0d err=%b expected 0 1 1",
                  to, mon_ends, dma_error);
      end
      checks++;
      if (post_err_req !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bus_error_request: got %b expected 0", post_err_req);
      end
      run_write(32'h7000, 4'hF, 8'd1, -1, -1, 1'b1, to);
      repeat (20) @(posedge clock);
      #1;
      checks++;
      if (to !== 1'b0 || mon_begins !== 1 || mon_rnw !== 1'b0 || mon_we !== 0 ||
          mon_beats !== 2 || dma_error !== 1'b0) begin
         failures++;
         $display("[TB] FAIL both_launch: timeout=%b begins=%0d rnw=%b we=%0d beats=%0d err=%b expected 0 1 0 0 2 0",
                  to, mon_begins, mon_rnw, mon_we, mon_beats, dma_error);
      end
   endtask

   task automatic test_reset_mid_read();
      logic to;
      logic started = 1'b0;
      logic done = 1'b0;
      int sent = 0;
      for (int i = 0; i < 4; i++) preload(i, 32'h77770000 + 32'(i));
      clear_monitor();
      dma_address    = 32'h3000;
      dma_burst_size = 8'd3;
      dma_readReady  = 1'b1;
      bus_grant      = 1'b1;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         @(posedge clock); #1;
         bus_data_valid_in   = 1'b0;
         bus_address_data_in = 32'd0;
         if (started && sent == 0) begin
            bus_data_valid_in   = 1'b1;
            bus_address_data_in = 32'hBEEF0001;
            sent++;
         end else if (started) begin
            dma_readReady = 1'b0;
            JRSTN = 1'b0;
            #1;
            done = 1'b1;
         end
         if (bus_begin_transaction_out) started = 1'b1;
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_mid_timeout: got %b expected 1", done);
      end
      checks++;
      if ({bus_request, bus_begin_transaction_out, bus_data_valid_out, bus_end_transaction_out,
           pp_writeEnable, dma_busy} !== 6'd0 || bus_address_data_out !== 32'd0 ||
          switch_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_mid_outputs: flags=%b addr_data=%h switch_ready=%b expected 000000 0 1",
                  {bus_request, bus_begin_transaction_out, bus_data_valid_out,
                   bus_end_transaction_out, pp_writeEnable, dma_busy},
                  bus_address_data_out, switch_ready);
      end
      checks++;
      if (mem[0] !== 32'hBEEF0001 || mem[1] !== 32'h77770001) begin
         failures++;
         $display("[TB] FAIL reset_mid_mem: got %h %h expected beef0001 77770001", mem[0], mem[1]);
      end
      repeat (3) @(posedge clock);
      #1;
      JRSTN = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      run_write(32'h5000, 4'hF, 8'd1, -1, -1, 1'b0, to);
      #1;
      checks++;
      if (to !== 1'b0 || mon_beats !== 2 || mon_ends !== 1 || beat_log[0] !== 32'hBEEF0001 ||
          beat_log[1] !== 32'h77770001) begin
         failures++;
         $display("[TB] FAIL reset_mid_recover: timeout=%b beats=%0d ends=%0d b0=%h b1=%h expected 0 2 1 beef0001 77770001",
                  to, mon_beats, mon_ends, beat_log[0], beat_log[1]);
      end
   endtask

   initial begin
      JRSTN = 1'b0;
      dma_address = 32'd0; dma_byte_enable = 4'd0; dma_burst_size = 8'd0;
      dma_data_ready = 1'b0; dma_readReady = 1'b0;
      bus_grant = 1'b0; bus_address_data_in = 32'd0; bus_data_valid_in = 1'b0;
      bus_busy_in = 1'b0; bus_end_transaction_in = 1'b0; bus_error_in = 1'b0;
      tb_we = 1'b0; tb_waddr = 9'd0; tb_wdata = 32'd0;
      mon_clear = 1'b1;
      post_err_req = 1'b0;
      test_reset();
      test_write_burst();
      test_write_busy();
      test_read_burst();
      test_read_early_end();
      test_bus_error();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
